// File: rtl/tipi_rpi_link.sv
// RPi serial register link front end for TIPI: synchronizes the RPi shift pins,
// assembles control/data frames and flags short frames. Optional readback: TIPI_LINK_READBACK_EN.
module tipi_rpi_link #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rpi_cclk,
    input  logic       rpi_dclk,
    input  logic       rpi_sdata,
    input  logic       rpi_le,
    input  logic [7:0] ti_control_in,
    input  logic [7:0] ti_data_in,
    input  logic       err_clr,
    output logic [7:0] rcontrol_out,
    output logic [7:0] rdata_out,
    output logic       rcontrol_stb,
    output logic       rdata_stb,
    output logic       frame_err,
    output logic       rpi_dout
);

    localparam int         CH_CTL    = 0;
    localparam int         CH_DAT    = 1;
    localparam int         NCH       = 2;
    localparam logic [2:0] GUARD_MAX = 3'(SYNC_STAGES + 1);
    localparam logic [3:0] CNT_FULL  = 4'd8;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } ch_state_t;

    logic [SYNC_STAGES-1:0] cclk_sync;
    logic [SYNC_STAGES-1:0] dclk_sync;
    logic [SYNC_STAGES-1:0] sdata_sync;
    logic [SYNC_STAGES-1:0] le_sync;

    logic [1:0] clk_s;
    logic [1:0] clk_prev;
    logic [1:0] edge_raw;
    logic       le_s;
    logic       sdata_s;
    logic [2:0] guard_q;

    logic [1:0] edge_p0;
    logic       le_p0;
    logic       sdata_p0;

    ch_state_t  state_q [NCH];
    ch_state_t  state_d [NCH];
    logic [3:0] cnt_q   [NCH];
    logic [3:0] cnt_d   [NCH];
    logic [7:0] sr_q    [NCH];
    logic [7:0] sr_d    [NCH];
    logic [1:0] commit;
    logic [1:0] short_commit;

    // ---- synchronizers: identical depth keeps clocks and data aligned ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cclk_sync  <= '0;
            dclk_sync  <= '0;
            sdata_sync <= '0;
            le_sync    <= '0;
        end else begin
            cclk_sync  <= {cclk_sync[SYNC_STAGES-2:0],  rpi_cclk};
            dclk_sync  <= {dclk_sync[SYNC_STAGES-2:0],  rpi_dclk};
            sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], rpi_sdata};
            le_sync    <= {le_sync[SYNC_STAGES-2:0],    rpi_le};
        end
    end

    assign clk_s    = {dclk_sync[SYNC_STAGES-1], cclk_sync[SYNC_STAGES-1]};
    assign le_s     = le_sync[SYNC_STAGES-1];
    assign sdata_s  = sdata_sync[SYNC_STAGES-1];
    assign edge_raw = clk_s & ~clk_prev;

    // ---- p0: edge detect, masked until the guard expires after reset ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_prev <= 2'b00;
            guard_q  <= GUARD_MAX;
            edge_p0  <= 2'b00;
            le_p0    <= 1'b0;
            sdata_p0 <= 1'b0;
        end else begin
            clk_prev <= clk_s;
            if (guard_q != 3'd0) begin
                guard_q <= guard_q - 3'd1;
            end
            edge_p0  <= (guard_q == 3'd0) ? edge_raw : 2'b00;
            le_p0    <= le_s;
            sdata_p0 <= sdata_s;
        end
    end

    // ---- p1: per-channel frame assembly FSM ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                state_q[c] <= EMPTY;
                cnt_q[c]   <= 4'd0;
                sr_q[c]    <= 8'd0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
                sr_q[c]    <= sr_d[c];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            state_d[c]      = state_q[c];
            cnt_d[c]        = cnt_q[c];
            sr_d[c]         = sr_q[c];
            commit[c]       = 1'b0;
            short_commit[c] = 1'b0;
            if (edge_p0[c]) begin
                if (le_p0) begin
                    // sr is kept: a short frame commits zero-extended history
                    commit[c]       = 1'b1;
                    short_commit[c] = (state_q[c] != FULL);
                    state_d[c]      = EMPTY;
                    cnt_d[c]        = 4'd0;
                end else begin
                    sr_d[c]    = {sr_q[c][6:0], sdata_p0};
                    cnt_d[c]   = (cnt_q[c] >= 4'd7) ? CNT_FULL : cnt_q[c] + 4'd1;
                    state_d[c] = (cnt_d[c] == CNT_FULL) ? FULL : PARTIAL;
                end
            end
        end
    end

    // ---- p2: committed frame registers, strobes and error flag ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcontrol_out <= 8'd0;
            rdata_out    <= 8'd0;
            rcontrol_stb <= 1'b0;
            rdata_stb    <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rcontrol_stb <= commit[CH_CTL];
            rdata_stb    <= commit[CH_DAT];
            if (commit[CH_CTL]) begin
                rcontrol_out <= sr_q[CH_CTL];
            end
            if (commit[CH_DAT]) begin
                rdata_out <= sr_q[CH_DAT];
            end
            if (|short_commit) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

`ifdef TIPI_LINK_READBACK_EN
    logic [7:0] tx_q [NCH];
    logic [7:0] tx_d [NCH];
    logic [7:0] tx_load [NCH];
    logic       sel_dat_q;
    logic       sel_dat_d;

    assign tx_load[CH_CTL] = ti_control_in;
    assign tx_load[CH_DAT] = ti_data_in;

    always_comb begin
        sel_dat_d = sel_dat_q;
        for (int c = 0; c < NCH; c++) begin
            tx_d[c] = tx_q[c];
            if (commit[c]) begin
                tx_d[c] = tx_load[c];
            end else if (edge_p0[c]) begin
                tx_d[c] = {tx_q[c][6:0], 1'b0};
            end
        end
        // data channel wins when both channels edge in the same cycle
        if (edge_p0[CH_DAT]) begin
            sel_dat_d = 1'b1;
        end else if (edge_p0[CH_CTL]) begin
            sel_dat_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                tx_q[c] <= 8'd0;
            end
            sel_dat_q <= 1'b0;
            rpi_dout  <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                tx_q[c] <= tx_d[c];
            end
            sel_dat_q <= sel_dat_d;
            rpi_dout  <= sel_dat_d ? tx_d[CH_DAT][7] : tx_d[CH_CTL][7];
        end
    end
`else
    logic unused_ti;

    assign unused_ti = ^{ti_control_in, ti_data_in};
    assign rpi_dout  = 1'b0;
`endif

endmodule

// File: tb/tb_tipi_rpi_link.sv
// Directed self-checking bench for tipi_rpi_link (default depth SYNC_STAGES=2).
module tb_tipi_rpi_link;

    logic       clk;
    logic       rst_n;
    logic       rpi_cclk;
    logic       rpi_dclk;
    logic       rpi_sdata;
    logic       rpi_le;
    logic [7:0] ti_control_in;
    logic [7:0] ti_data_in;
    logic       err_clr;
    logic [7:0] rcontrol_out;
    logic [7:0] rdata_out;
    logic       rcontrol_stb;
    logic       rdata_stb;
    logic       frame_err;
    logic       rpi_dout;

    int total = 0;
    int bad   = 0;
    int n_cstb = 0;
    int n_dstb = 0;

    tipi_rpi_link #(.SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rpi_cclk      (rpi_cclk),
        .rpi_dclk      (rpi_dclk),
        .rpi_sdata     (rpi_sdata),
        .rpi_le        (rpi_le),
        .ti_control_in (ti_control_in),
        .ti_data_in    (ti_data_in),
        .err_clr       (err_clr),
        .rcontrol_out  (rcontrol_out),
        .rdata_out     (rdata_out),
        .rcontrol_stb  (rcontrol_stb),
        .rdata_stb     (rdata_stb),
        .frame_err     (frame_err),
        .rpi_dout      (rpi_dout)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (rcontrol_stb) n_cstb++;
        if (rdata_stb)    n_dstb++;
    end

    // ch: 0 = control clock, 1 = data clock, 2 = both in the same cycle
    task automatic set_pins(input int ch, input logic v);
        if (ch != 1) rpi_cclk = v;
        if (ch != 0) rpi_dclk = v;
    endtask

    task automatic pulse_ch(input int ch, input logic b, input logic le);
        @(negedge clk);
        rpi_sdata = b;
        rpi_le    = le;
        @(negedge clk);
        set_pins(ch, 1'b1);
        repeat (4) @(negedge clk);
        set_pins(ch, 1'b0);
        repeat (4) @(negedge clk);
        rpi_le = 1'b0;
    endtask

    task automatic shift_byte(input int ch, input logic [7:0] v);
        for (int i = 7; i >= 0; i--) pulse_ch(ch, v[i], 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rpi_cclk = 0; rpi_dclk = 0; rpi_sdata = 0; rpi_le = 0;
        ti_control_in = 8'h00; ti_data_in = 8'h00; err_clr = 0;
        repeat (3) @(negedge clk);
        total++; if (rcontrol_out !== 8'h00) begin bad++; $display("FAIL reset_rcontrol got=%h exp=00", rcontrol_out); end
        total++; if (rdata_out !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h exp=00", rdata_out); end
        total++; if (rcontrol_stb !== 1'b0) begin bad++; $display("FAIL reset_cstb got=%b exp=0", rcontrol_stb); end
        total++; if (rdata_stb !== 1'b0) begin bad++; $display("FAIL reset_dstb got=%b exp=0", rdata_stb); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", frame_err); end
        total++; if (rpi_dout !== 1'b0) begin bad++; $display("FAIL reset_dout got=%b exp=0", rpi_dout); end
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_control_frame();
        int c0;
        c0 = n_cstb;
        shift_byte(0, 8'hA5);
        @(negedge clk);
        rpi_sdata = 1'b0;
        rpi_le    = 1'b1;
        @(negedge clk);
        rpi_cclk = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            total++;
            if (rcontrol_stb !== (i == 4)) begin
                bad++; $display("FAIL latency_cstb cycle=%0d got=%b exp=%b", i, rcontrol_stb, (i == 4));
            end
        end
        rpi_cclk = 1'b0;
        repeat (4) @(negedge clk);
        rpi_le = 1'b0;
        total++; if (rcontrol_out !== 8'hA5) begin bad++; $display("FAIL ctl_a5 got=%h exp=a5", rcontrol_out); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL ctl_a5_err got=%b exp=0", frame_err); end
        total++; if (n_cstb - c0 !== 1) begin bad++; $display("FAIL ctl_a5_stbcount got=%0d exp=1", n_cstb - c0); end
    endtask

    task automatic test_interleaved();
        logic [7:0] d, c;
        int c0, d0;
        d = 8'h3C; c = 8'hC3; c0 = n_cstb; d0 = n_dstb;
        for (int i = 7; i >= 0; i--) begin
            pulse_ch(1, d[i], 1'b0);
            pulse_ch(0, c[i], 1'b0);
        end
        pulse_ch(2, 1'b0, 1'b1);
        total++; if (rdata_out !== 8'h3C) begin bad++; $display("FAIL ilv_data got=%h exp=3c", rdata_out); end
        total++; if (rcontrol_out !== 8'hC3) begin bad++; $display("FAIL ilv_ctl got=%h exp=c3", rcontrol_out); end
        total++; if (n_cstb - c0 !== 1) begin bad++; $display("FAIL ilv_cstb got=%0d exp=1", n_cstb - c0); end
        total++; if (n_dstb - d0 !== 1) begin bad++; $display("FAIL ilv_dstb got=%0d exp=1", n_dstb - d0); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL ilv_err got=%b exp=0", frame_err); end
    endtask

    task automatic test_back_to_back();
        shift_byte(2, 8'h69);
        pulse_ch(2, 1'b1, 1'b1);
        total++; if (rdata_out !== 8'h69) begin bad++; $display("FAIL both_data got=%h exp=69", rdata_out); end
        total++; if (rcontrol_out !== 8'h69) begin bad++; $display("FAIL both_ctl got=%h exp=69", rcontrol_out); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL both_err got=%b exp=0", frame_err); end
    endtask

    task automatic test_short_frame();
        logic [4:0] bits;
        int d0;
        bits = 5'b10110;
        do_reset();
        d0 = n_dstb;
        for (int i = 4; i >= 0; i--) pulse_ch(1, bits[i], 1'b0);
        pulse_ch(1, 1'b0, 1'b1);
        total++; if (rdata_out !== 8'h16) begin bad++; $display("FAIL short_data got=%h exp=16", rdata_out); end
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL short_err got=%b exp=1", frame_err); end
        total++; if (n_dstb - d0 !== 1) begin bad++; $display("FAIL short_dstb got=%0d exp=1", n_dstb - d0); end
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL errclr got=%b exp=0", frame_err); end
        // empty latch lands on the same cycle as err_clr
        @(negedge clk); rpi_le = 1'b1;
        @(negedge clk); rpi_dclk = 1'b1;
        repeat (3) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL set_beats_clr got=%b exp=1", frame_err); end
        total++; if (rdata_out !== 8'h16) begin bad++; $display("FAIL sr_kept got=%h exp=16", rdata_out); end
        rpi_dclk = 1'b0;
        repeat (4) @(negedge clk);
        rpi_le = 1'b0;
    endtask

    task automatic test_long_frame();
        logic [9:0] bits;
        bits = 10'b11_0101_1010;
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        for (int i = 9; i >= 0; i--) pulse_ch(0, bits[i], 1'b0);
        pulse_ch(0, 1'b0, 1'b1);
        total++; if (rcontrol_out !== 8'h5A) begin bad++; $display("FAIL long_ctl got=%h exp=5a", rcontrol_out); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL long_err got=%b exp=0", frame_err); end
    endtask

    task automatic test_reset_guard();
        int c0;
        @(negedge clk);
        rst_n = 1'b0; rpi_cclk = 1'b1; rpi_le = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (rcontrol_out !== 8'h00) begin bad++; $display("FAIL guard_rst_ctl got=%h exp=00", rcontrol_out); end
        c0 = n_cstb;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        total++; if (n_cstb - c0 !== 0) begin bad++; $display("FAIL guard_stb got=%0d exp=0", n_cstb - c0); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL guard_err got=%b exp=0", frame_err); end
        rpi_cclk = 1'b0; rpi_le = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] bits;
        bits = 4'b1010;
        shift_byte(1, 8'h81);
        pulse_ch(1, 1'b0, 1'b1);
        total++; if (rdata_out !== 8'h81) begin bad++; $display("FAIL mid_pre_data got=%h exp=81", rdata_out); end
        for (int i = 3; i >= 0; i--) pulse_ch(0, bits[i], 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (rdata_out !== 8'h00) begin bad++; $display("FAIL mid_rst_data got=%h exp=00", rdata_out); end
        total++; if (rcontrol_out !== 8'h00) begin bad++; $display("FAIL mid_rst_ctl got=%h exp=00", rcontrol_out); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL mid_rst_err got=%b exp=0", frame_err); end
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        shift_byte(0, 8'hFF);
        pulse_ch(0, 1'b0, 1'b1);
        total++; if (rcontrol_out !== 8'hFF) begin bad++; $display("FAIL mid_ff got=%h exp=ff", rcontrol_out); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL mid_ff_err got=%b exp=0", frame_err); end
    endtask

    task automatic test_readback();
        logic [7:0] exp_rb;
`ifdef TIPI_LINK_READBACK_EN
        exp_rb = 8'h81;
`else
        exp_rb = 8'h00;
`endif
        ti_data_in    = 8'h81;
        ti_control_in = 8'h00;
        pulse_ch(1, 1'b0, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            rpi_sdata = 1'b0;
            rpi_le    = 1'b0;
            @(negedge clk);
            total++;
            if (rpi_dout !== exp_rb[i]) begin
                bad++; $display("FAIL readback bit=%0d got=%b exp=%b", 7 - i, rpi_dout, exp_rb[i]);
            end
            rpi_dclk = 1'b1;
            repeat (4) @(negedge clk);
            rpi_dclk = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_control_frame();
        test_interleaved();
        test_back_to_back();
        test_short_frame();
        test_long_frame();
        test_reset_guard();
        test_reset_mid_frame();
        test_readback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
